pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Parametrised successor to the single-cycle PC/fetch path in yChip: owns the program counter, issues instruction-memory requests over a valid/ready handshake, buffers responses in a DEPTH-entry prefetch FIFO, and hands instructions to decode with PC and PC+4.
- Adds branch/jump redirect with flush, and vectored, prioritised interrupt entry. Entry point is loaded on reset.

Parameters:
- XLEN, 32, address/PC width.
- DEPTH, 4, prefetch FIFO entries; power of 2, ≥2.
- NUM_IRQ, 4, interrupt request lines.
- VEC_BASE, 32'h100, interrupt vector table base.
- VEC_STRIDE, 4, byte distance between vectors.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- entry_point  in  XLEN  PC loaded while rst_n=0.
- irq  in  NUM_IRQ  level interrupt requests; bit 0 highest priority.
- irq_en  in  1  global interrupt enable.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address.
- imem_rsp_valid  in  1  response strobe; responses in order, ≥1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- ins_valid  out  1  FIFO head valid.
- ins_ready  in  1  decode consumes head.
- ins  out  32  head instruction.
- ins_pc  out  XLEN  head PC.
- ins_pcp4  out  XLEN  ins_pc+4.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  XLEN  target; bits[1:0] ignored (forced 0).
- irq_taken  out  1  one-cycle pulse on interrupt entry.
- irq_id  out  $clog2(NUM_IRQ)  taken line; held until next entry.
- epc  out  XLEN  PC of first instruction not delivered at entry; held.

Behaviour:
- Reset (rst_n=0 at a rising edge): fetch_pc<=entry_point with bits[1:0] forced 0; FIFO empty; outstanding=0; drop_cnt=0; irq_taken=0; irq_id=0; epc=0; imem_req_valid=0; ins_valid=0. Reset applied mid-transfer discards all in-flight responses. Responses arriving in the first cycle after reset are ignored.
- Request issue: imem_req_valid=1 when (fifo_count+outstanding) < DEPTH and no flush is occurring this cycle. imem_req_addr=fetch_pc.
- On req_valid&&req_ready: fetch_pc+=4 (wraps modulo 2^XLEN); outstanding++.
- Response:
  - If drop_cnt>0: discard and decrement drop_cnt.
  - Otherwise push {data, pc}, where pc is taken from an internal in-order tag queue of issued addresses.
  - outstanding-- in both cases.
  - The same-cycle request and response update outstanding net.
- Delivery: ins/ins_pc come from the FIFO head and are valid when non-empty. Pop on ins_valid&&ins_ready. Push and pop in the same cycle are legal when full or empty. No combinational path from rsp to ins; minimum latency is request accept → ins_valid 2 cycles.
- Redirect (highest priority), effective next cycle:
  - FIFO cleared; drop_cnt<=outstanding (less any response consumed that cycle); fetch_pc<=redirect_pc.
  - No request is issued in the redirect cycle.
  - A pop in the same cycle still completes.
- Interrupt: condition irq_en && |irq && !redirect_valid.
  - Selected id = lowest set bit.
  - epc<=head pc if FIFO non-empty, else the PC of the oldest outstanding non-dropped fetch, else fetch_pc.
  - Flush as for a redirect, to VEC_BASE+id*VEC_STRIDE.
  - irq_taken=1 for exactly that cycle.
  - If irq stays asserted, a new entry is blocked until irq_en deasserts then reasserts. Track with an internal armed flag, set on reset.
  - Redirect and irq in the same cycle: redirect taken, irq evaluated again next cycle.
- State machine: RUN, FLUSH (drop_cnt>0; requests allowed, responses discarded), back to RUN when drop_cnt reaches 0.

Optional Feature:
- Macro PC_FETCH_PERF_EN.
- Defined: adds outputs perf_ins_cnt[31:0] (increments per pop) and perf_flush_cnt[31:0] (increments per redirect or interrupt flush). Both reset to 0 and wrap.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with entry_point=32'h28, memory ready always, 1-cycle latency, returning addr-derived data → ins_pc sequence 28,2C,30…, ins_pcp4=ins_pc+4, first ins_valid 2 cycles after first accept.
- ins_ready=0 for 10 cycles → exactly DEPTH=4 entries buffered, imem_req_valid=0 once full. ins_ready=1 → 4 back-to-back pops, no loss or duplicates.
- With 2 fetches outstanding, redirect_pc=32'h80 → both stale responses dropped, next delivered ins_pc=80.
- irq=4'b0110, irq_en=1, head pc=34 → irq_taken pulse, irq_id=1, epc=34, next ins_pc=32'h104. No second entry while irq is held.
- redirect_valid and irq[0] in the same cycle → redirect target delivered first path-wise, irq entry 1 cycle later with irq_id=0.
- rst_n low mid-stream with a response in flight → all outputs at reset values, fetch restarts at entry_point, late response ignored.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
interface pc_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [31:0]     rsp_data;

    modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
    modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/pc_fetch_unit.sv
// PC ownership, prefetch FIFO, redirect flush and vectored interrupt entry.
// Optional PC_FETCH_PERF_EN adds pop and flush event counters.
module pc_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 4,
    parameter int              NUM_IRQ    = 4,
    parameter logic [XLEN-1:0] VEC_BASE   = 32'h100,
    parameter int              VEC_STRIDE = 4,
    localparam int             IDW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [XLEN-1:0]     entry_point,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic                irq_en,
    pc_fetch_unit_if.master     imem,
    output logic                ins_valid,
    input  logic                ins_ready,
    output logic [31:0]         ins,
    output logic [XLEN-1:0]     ins_pc,
    output logic [XLEN-1:0]     ins_pcp4,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                irq_taken,
    output logic [IDW-1:0]      irq_id,
    output logic [XLEN-1:0]     epc
`ifdef PC_FETCH_PERF_EN
    ,
    output logic [31:0]         perf_ins_cnt,
    output logic [31:0]         perf_flush_cnt
`endif
);
    // state | meaning
    // RUN   | responses are pushed into the prefetch FIFO
    // FLUSH | drop_cnt > 0, stale responses discarded, new requests allowed
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {RUN, FLUSH} state_t;
    state_t state, state_next;

    logic [XLEN-1:0] fetch_pc;
    logic [31:0]     fifo_data [DEPTH];
    logic [XLEN-1:0] fifo_pc   [DEPTH];
    logic [XLEN-1:0] tag_q     [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr, tag_rd, tag_wr;
    logic [CW-1:0]   count, outstanding, drop_cnt;
    logic [CW-1:0]   count_next, outst_next, drop_next;
    logic            rsp_ok, armed;
    logic            irq_fire, flush, req_fire, rsp_fire, pop, push, rsp_drop;
    logic [IDW-1:0]  sel_id;
    logic [XLEN-1:0] target, epc_src;
    logic            unused_bits;

    assign unused_bits = ^{redirect_pc[1:0], entry_point[1:0]};

    assign irq_fire = irq_en && armed && (|irq) && !redirect_valid;
    assign flush    = redirect_valid || irq_fire;
    assign req_fire = imem.req_valid && imem.req_ready;
    // rsp_ok blanks the first cycle after reset; outstanding guards stray strobes
    assign rsp_fire = imem.rsp_valid && rsp_ok && (outstanding != '0);
    assign pop      = ins_valid && ins_ready;

    assign imem.req_valid = rst_n && !flush &&
                            (((CW+1)'(count) + (CW+1)'(outstanding)) < (CW+1)'(DEPTH));
    assign imem.req_addr  = fetch_pc;

    assign ins_valid = (count != '0);
    assign ins       = fifo_data[rd_ptr];
    assign ins_pc    = fifo_pc[rd_ptr];
    assign ins_pcp4  = fifo_pc[rd_ptr] + XLEN'(4);

    always_comb begin
        sel_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq[i]) sel_id = IDW'(i);
        end
    end

    assign target = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00}
                                   : VEC_BASE + XLEN'(sel_id) * XLEN'(VEC_STRIDE);

    // Oldest non-dropped in-flight fetch sits drop_cnt entries past the tag head
    assign epc_src = (count != '0)            ? fifo_pc[rd_ptr] :
                     (outstanding > drop_cnt) ? tag_q[tag_rd + AW'(drop_cnt)] :
                                                fetch_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    always_comb begin
        outst_next = outstanding + CW'(req_fire) - CW'(rsp_fire);
        drop_next  = drop_cnt;
        if (flush)                    drop_next = outst_next;
        else if (rsp_fire && rsp_drop) drop_next = drop_cnt - CW'(1);
        state_next = (drop_next != '0) ? FLUSH : RUN;
    end

    always_comb begin
        rsp_drop   = (state == FLUSH);
        push       = rsp_fire && !rsp_drop && !flush;
        count_next = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (req_fire) tag_q[tag_wr] <= fetch_pc;
        if (push) begin
            fifo_data[wr_ptr] <= imem.rsp_data;
            fifo_pc[wr_ptr]   <= tag_q[tag_rd];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= {entry_point[XLEN-1:2], 2'b00};
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rsp_ok      <= 1'b0;
            armed       <= 1'b1;
            irq_taken   <= 1'b0;
            irq_id      <= '0;
            epc         <= '0;
        end else begin
            rsp_ok      <= 1'b1;
            outstanding <= outst_next;
            drop_cnt    <= drop_next;
            if (req_fire) tag_wr <= tag_wr + AW'(1);
            if (rsp_fire) tag_rd <= tag_rd + AW'(1);
            if (flush) begin
                fetch_pc <= target;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
                if (push)     wr_ptr   <= wr_ptr + AW'(1);
                if (pop)      rd_ptr   <= rd_ptr + AW'(1);
                count <= count_next;
            end
            irq_taken <= irq_fire;
            if (irq_fire) begin
                irq_id <= sel_id;
                epc    <= epc_src;
            end
            if (!irq_en)       armed <= 1'b1;
            else if (irq_fire) armed <= 1'b0;
        end
    end

`ifdef PC_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_ins_cnt   <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pop)   perf_ins_cnt   <= perf_ins_cnt + 32'd1;
            if (flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: behavioural memory with variable latency, path scoreboard.
module tb_pc_fetch_unit;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [XLEN-1:0] entry_point;
    logic [3:0]      irq;
    logic            irq_en;
    logic            ins_valid, ins_ready;
    logic [31:0]     ins;
    logic [XLEN-1:0] ins_pc, ins_pcp4;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            irq_taken;
    logic [1:0]      irq_id;
    logic [XLEN-1:0] epc;
`ifdef PC_FETCH_PERF_EN
    logic [31:0]     perf_ins_cnt, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    pc_fetch_unit_if #(.XLEN(XLEN)) imem ();

    pc_fetch_unit #(.XLEN(XLEN), .DEPTH(4), .NUM_IRQ(4), .VEC_BASE(32'h100), .VEC_STRIDE(4)) dut (
        .clk(clk), .rst_n(rst_n), .entry_point(entry_point), .irq(irq), .irq_en(irq_en),
        .imem(imem), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
        .ins_pc(ins_pc), .ins_pcp4(ins_pcp4), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .irq_taken(irq_taken), .irq_id(irq_id), .epc(epc)
`ifdef PC_FETCH_PERF_EN
        , .perf_ins_cnt(perf_ins_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int mem_lat = 1;
    int pops = 0;
    int taken_cnt = 0;
    int first_acc = -1;
    int first_iv = -1;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] sb_q[$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_path(input logic [31:0] start);
        sb_q.delete();
        for (int i = 0; i < 48; i++) sb_q.push_back(start + 32'(4 * i));
    endtask

    // One clock: sample at the falling edge, then play memory responses just after the rising edge.
    task automatic tick();
        logic [31:0] exp_pc;
        @(negedge clk);
        if (ins_valid && ins_ready) begin
            pops++;
            exp_pc = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hFFFF_FFFF;
            chk("ins_pc", ins_pc, exp_pc);
            chk("ins", ins, mem_data(exp_pc));
            chk("ins_pcp4", ins_pcp4, exp_pc + 32'd4);
        end
        if (irq_taken) taken_cnt++;
        if (ins_valid && first_iv < 0) first_iv = cyc;
        if (imem.req_valid && imem.req_ready) begin
            pend_addr.push_back(imem.req_addr);
            pend_due.push_back(cyc + mem_lat);
            if (first_acc < 0) first_acc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
            imem.rsp_valid = 1'b1;
            imem.rsp_data  = mem_data(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem.rsp_valid = 1'b0;
            imem.rsp_data  = 32'h0;
        end
    endtask

    initial begin
        int p0, t0;
        rst_n = 1'b0; entry_point = 32'h28; irq = 4'b0; irq_en = 1'b0; ins_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        imem.req_ready = 1'b1; imem.rsp_valid = 1'b0; imem.rsp_data = 32'h0;

        // reset values
        tick();
        chk("rst_req_valid", {31'b0, imem.req_valid}, 32'd0);
        chk("rst_ins_valid", {31'b0, ins_valid}, 32'd0);
        chk("rst_irq_taken", {31'b0, irq_taken}, 32'd0);
        chk("rst_irq_id", {30'b0, irq_id}, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_addr", imem.req_addr, 32'h28);

        // sequential stream from entry point
        rst_n = 1'b1; ins_ready = 1'b1; sb_path(32'h28);
        for (int i = 0; i < 10; i++) tick();
        chk("first_latency", 32'(first_iv - first_acc), 32'd2);
        chk("stream_pops", {31'b0, pops >= 6}, 32'd1);

        // backpressure fills exactly DEPTH entries
        ins_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("full_ins_valid", {31'b0, ins_valid}, 32'd1);
        chk("full_no_req", {31'b0, imem.req_valid}, 32'd0);
        ins_ready = 1'b1; imem.req_ready = 1'b0; p0 = pops;
        for (int i = 0; i < 6; i++) tick();
        chk("drain_pops", 32'(pops - p0), 32'd4);
        chk("drain_empty", {31'b0, ins_valid}, 32'd0);

        // redirect with two fetches outstanding
        imem.req_ready = 1'b1; mem_lat = 3;
        tick(); tick();
        chk("two_outstanding", 32'(pend_due.size()), 32'd2);
        imem.req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h81;
        #1;
        chk("redir_no_req", {31'b0, imem.req_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0; imem.req_ready = 1'b1; mem_lat = 1; sb_path(32'h80);
        p0 = pops;
        for (int i = 0; i < 10; i++) tick();
        chk("redir_delivered", {31'b0, (pops - p0) >= 4}, 32'd1);

        // interrupt with FIFO holding 34..40
        ins_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h34;
        tick();
        redirect_valid = 1'b0; sb_path(32'h34);
        for (int i = 0; i < 10; i++) tick();
        chk("pre_irq_head", ins_pc, 32'h34);
        irq = 4'b0110; irq_en = 1'b1; t0 = taken_cnt;
        tick();
        sb_path(32'h104);
        chk("irq_taken", {31'b0, irq_taken}, 32'd1);
        chk("irq_id", {30'b0, irq_id}, 32'd1);
        chk("irq_epc", epc, 32'h34);
        chk("irq_flush", {31'b0, ins_valid}, 32'd0);
        ins_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("irq_single", 32'(taken_cnt - t0), 32'd1);

        // redirect and irq[0] together: redirect first, entry one cycle later
        irq_en = 1'b0;
        tick();
        irq = 4'b0001; irq_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        sb_path(32'h200);
        chk("redir_irq_no_take", {31'b0, irq_taken}, 32'd0);
        redirect_valid = 1'b0;
        tick();
        sb_path(32'h100);
        chk("late_irq_taken", {31'b0, irq_taken}, 32'd1);
        chk("late_irq_id", {30'b0, irq_id}, 32'd0);
        chk("late_irq_epc", epc, 32'h200);
        for (int i = 0; i < 8; i++) tick();
        chk("late_irq_pulse_end", {31'b0, irq_taken}, 32'd0);

        // reset mid-stream with a response in flight
        irq = 4'b0; irq_en = 1'b0; mem_lat = 2;
        for (int i = 0; i < 6; i++) tick();
        entry_point = 32'h43; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; sb_path(32'h40);
        chk("mid_rst_ins_valid", {31'b0, ins_valid}, 32'd0);
        chk("mid_rst_irq_taken", {31'b0, irq_taken}, 32'd0);
        chk("mid_rst_irq_id", {30'b0, irq_id}, 32'd0);
        chk("mid_rst_epc", epc, 32'd0);
        chk("mid_rst_addr", imem.req_addr, 32'h40);
        tick();
        chk("late_rsp_ignored", {31'b0, ins_valid}, 32'd0);
        p0 = pops;
        for (int i = 0; i < 10; i++) tick();
        chk("restart_delivered", {31'b0, (pops - p0) >= 4}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
